// File: rtl/seq_mul_if.sv
// Start/busy/done handshake and operand/product bus for seq_mul_ctrl.
interface seq_mul_if #(
    parameter int A_W = 3
);
    logic           start;
    logic [A_W-1:0] a;
    logic [3:0]     b;
    logic           busy;
    logic           done;
    logic [A_W+3:0] p;

    modport master (output start, a, b, input busy, done, p);
    modport slave  (input start, a, b, output busy, done, p);
endinterface

// File: rtl/seq_mul_ctrl.sv
// Shift-add multiplier sharing one 4-bit ripple adder, one partial product per clock.
// Optional SEQ_MUL_EARLY_TERM_EN: finish as soon as the unconsumed multiplier bits are zero.
module ripple_carry_4_bit_adder (
    input  logic [3:0] x_i,
    input  logic [3:0] y_i,
    input  logic       ci_i,
    output logic [3:0] s_o,
    output logic       co_o
);
    always_comb begin
        logic [4:0] c;
        c    = '0;
        c[0] = ci_i;
        s_o  = '0;
        for (int i = 0; i < 4; i++) begin
            s_o[i]   = x_i[i] ^ y_i[i] ^ c[i];
            c[i + 1] = (x_i[i] & y_i[i]) | (c[i] & (x_i[i] ^ y_i[i]));
        end
        co_o = c[4];
    end
endmodule

module seq_mul_ctrl #(
    parameter int A_W = 3
) (
    input  logic     clk,
    input  logic     rst,
    seq_mul_if.slave bus
);
    localparam int CW = (A_W > 1) ? $clog2(A_W) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state_q, state_d;
    logic [3:0]     breg_q, breg_d;
    logic [3:0]     hi_q, hi_d;
    logic [A_W-1:0] lo_q, lo_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [A_W+3:0] p_q, p_d;

    logic [3:0]     sum;
    logic           co;
    logic [A_W+4:0] ext;
    logic [A_W+3:0] acc;
    logic [A_W+3:0] res;
    logic           last;

    ripple_carry_4_bit_adder u_add (
        .x_i  (hi_q),
        .y_i  (breg_q),
        .ci_i (1'b0),
        .s_o  (sum),
        .co_o (co)
    );

    // Carry is kept in the top bit, so the shifted window never overflows.
    always_comb begin
        ext = lo_q[0] ? {co, sum, lo_q} : {1'b0, hi_q, lo_q};
        acc = ext[A_W+4:1];
    end

`ifdef SEQ_MUL_EARLY_TERM_EN
    logic rest;
    always_comb begin
        rest = 1'b0;
        for (int j = 1; j < A_W; j++) begin
            if (j <= A_W - 1 - int'(cnt_q)) rest = rest | lo_q[j];
        end
        last = (int'(cnt_q) == A_W - 1) || !rest;
        res  = acc >> (A_W - 1 - int'(cnt_q));
    end
`else
    assign last = (int'(cnt_q) == A_W - 1);
    assign res  = acc;
`endif

    always_comb begin
        state_d = state_q;
        breg_d  = breg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CALC;
                    breg_d  = bus.b;
                    hi_d    = '0;
                    lo_d    = bus.a;
                    cnt_d   = '0;
                end
            end
            CALC: begin
                {hi_d, lo_d} = acc;
                cnt_d        = cnt_q + CW'(1);
                if (last) begin
                    p_d     = res;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            breg_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            breg_q  <= breg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    assign bus.busy = (state_q == CALC);
    assign bus.done = (state_q == DONE);
    assign bus.p    = p_q;
endmodule
